rp_adc_snapshot: RTL and testbench

Triggered snapshot capture buffer for the two registered ADC channels. It sits directly downstream of the ADC input register stage, in the `adc_clk` domain. Once armed, it waits for a level crossing on channel 0 or a forced trigger. It then writes 2^ADDR_WIDTH consecutive sample pairs into an internal dual-port RAM, and exposes them through a synchronous read port for readout logic such as a register bridge.

---
 rtl/rp_adc_snapshot_if.sv | 17 +
 rtl/rp_adc_snapshot.sv | 87 ++++++++
 tb/tb_rp_adc_snapshot.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rp_adc_snapshot_if.sv
// rp_adc_snapshot_if: sample, trigger-control and readout signals of the snapshot buffer.
interface rp_adc_snapshot_if #(
    parameter int ADC_BITWIDTH = 14,
    parameter int ADDR_WIDTH   = 10
);
    logic [ADC_BITWIDTH-1:0] adc0_in, adc1_in, trig_level, rd_data0, rd_data1;
    logic                    arm, force_trig, trig_en, rd_en, rd_valid, armed, busy, done;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    modport master (
        output adc0_in, adc1_in, arm, force_trig, trig_en, trig_level, rd_en, rd_addr,
        input  rd_data0, rd_data1, rd_valid, armed, busy, done
    );
    modport slave (
        input  adc0_in, adc1_in, arm, force_trig, trig_en, trig_level, rd_en, rd_addr,
        output rd_data0, rd_data1, rd_valid, armed, busy, done
    );
endinterface

// File: rtl/rp_adc_snapshot.sv
// rp_adc_snapshot: armed, triggered capture of 2^ADDR_WIDTH ADC sample pairs into a
// read-first dual-port RAM with a 1-cycle synchronous read port.
module rp_adc_snapshot #(
    parameter int ADC_BITWIDTH = 14,
    parameter int ADDR_WIDTH   = 10
) (
    input logic               adc_clk,
    input logic               rst,
    rp_adc_snapshot_if.slave  bus
);
    localparam int W = ADC_BITWIDTH;
    localparam int N = 1 << ADDR_WIDTH;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    state_t                r_state, w_next;
    logic [ADDR_WIDTH:0]   r_wr_cnt, w_wr_cnt_nxt;
    logic [W-1:0]          r_prev;
    logic                  r_prev_vld;
    logic [2*W-1:0]        r_mem [N];
    logic [2*W-1:0]        r_rd;
    logic                  r_rd_valid;
    logic                  w_cross, w_trig, w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;

    // r_prev_vld only qualifies the previous sample once a full ARMED cycle has elapsed
    assign w_cross = r_prev_vld && ($signed(r_prev) < $signed(bus.trig_level)) &&
                     ($signed(bus.adc0_in) >= $signed(bus.trig_level));
    assign w_trig  = bus.force_trig || (bus.trig_en && w_cross);
    assign w_waddr = r_wr_cnt[ADDR_WIDTH-1:0];

    always_comb begin
        w_next       = r_state;
        w_wr_cnt_nxt = '0;
        w_we         = 1'b0;
        case (r_state)
            IDLE, DONE: w_next = bus.arm ? ARMED : r_state;
            ARMED: begin
                w_next       = w_trig ? CAPTURE : ARMED;
                w_we         = w_trig;
                w_wr_cnt_nxt = w_trig ? (ADDR_WIDTH+1)'(1) : '0;
            end
            CAPTURE: begin
                w_we         = 1'b1;
                w_wr_cnt_nxt = r_wr_cnt + 1'b1;
                w_next       = (r_wr_cnt == (ADDR_WIDTH+1)'(N-1)) ? DONE : CAPTURE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wr_cnt   <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_prev     <= bus.adc0_in;
            r_prev_vld <= (r_state == ARMED);
        end
    end

    always_ff @(posedge adc_clk) begin
        if (w_we && !rst)
            r_mem[w_waddr] <= {bus.adc1_in, bus.adc0_in};
    end

    // Read-first: a same-cycle write is not visible to this read
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            r_rd       <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en)
                r_rd <= r_mem[bus.rd_addr];
        end
    end

    assign bus.rd_data0 = r_rd[W-1:0];
    assign bus.rd_data1 = r_rd[2*W-1:W];
    assign bus.rd_valid = r_rd_valid;
    assign bus.armed    = (r_state == ARMED);
    assign bus.busy     = (r_state == CAPTURE);
    assign bus.done     = (r_state == DONE);
endmodule

// File: tb/tb_rp_adc_snapshot.sv
// tb_rp_adc_snapshot: directed and random stimulus against a cycle-indexed reference
// model of the snapshot buffer (trigger cycle + sample history -> expected RAM).
module tb_rp_adc_snapshot;
    localparam int W  = 14;
    localparam int AW = 4;
    localparam int N  = 1 << AW;
    typedef enum {M_IDLE, M_ARMED, M_CAP, M_DONE} mst_t;

    logic adc_clk = 1'b0;
    logic rst     = 1'b1;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   base    = 0;

    mst_t                m_st       = M_IDLE;
    int                  m_cyc      = 0;
    int                  m_arm_cyc  = 0;
    int                  m_trig_cyc = 0;
    logic signed [W-1:0] m_prev     = '0;
    logic [W-1:0]        m_mem0 [N];
    logic [W-1:0]        m_mem1 [N];
    bit                  m_known [N];
    bit                  m_rv = 1'b0;
    bit                  m_dk = 1'b0;
    logic [W-1:0]        m_d0 = '0;
    logic [W-1:0]        m_d1 = '0;
    bit                  g_ramp = 1'b0;

    always #5 adc_clk = ~adc_clk;

    rp_adc_snapshot_if #(.ADC_BITWIDTH(W), .ADDR_WIDTH(AW)) bus ();
    rp_adc_snapshot #(.ADC_BITWIDTH(W), .ADDR_WIDTH(AW)) dut (
        .adc_clk(adc_clk),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Applies the behaviour at the edge closing cycle m_cyc to the model
    task automatic model_edge();
        logic signed [W-1:0] cur, lvl;
        mst_t ps;
        bit   trig;
        int   idx;
        cur  = bus.adc0_in;
        lvl  = bus.trig_level;
        ps   = m_st;
        trig = 1'b0;
        if (rst) begin
            m_st = M_IDLE;
            m_rv = 1'b0;
            m_d0 = '0;
            m_d1 = '0;
            m_dk = 1'b1;
        end else begin
            m_rv = bus.rd_en;
            if (bus.rd_en) begin
                m_d0 = m_mem0[bus.rd_addr];
                m_d1 = m_mem1[bus.rd_addr];
                m_dk = m_known[bus.rd_addr] && ps != M_CAP;
            end
            if ((ps == M_IDLE || ps == M_DONE) && bus.arm) begin
                m_st      = M_ARMED;
                m_arm_cyc = m_cyc;
            end
            if (ps == M_ARMED) begin
                trig = bus.force_trig ||
                       (bus.trig_en && m_cyc >= m_arm_cyc + 2 && m_prev < lvl && cur >= lvl);
                if (trig) begin
                    m_trig_cyc = m_cyc;
                    m_st       = M_CAP;
                end
            end
            if (trig || ps == M_CAP) begin
                idx          = m_cyc - m_trig_cyc;
                m_mem0[idx]  = bus.adc0_in;
                m_mem1[idx]  = bus.adc1_in;
                m_known[idx] = 1'b1;
                if (idx == N - 1)
                    m_st = M_DONE;
            end
        end
        m_prev = cur;
        m_cyc++;
    endtask

    task automatic step();
        model_edge();
        @(posedge adc_clk);
        #1;
        chk("armed", bus.armed, m_st == M_ARMED);
        chk("busy", bus.busy, m_st == M_CAP);
        chk("done", bus.done, m_st == M_DONE);
        chk("rd_valid", bus.rd_valid, m_rv);
        if (m_dk) begin
            chk("rd_data0", bus.rd_data0, m_d0);
            chk("rd_data1", bus.rd_data1, m_d1);
        end
    endtask

    task automatic cyc(input int a0, input bit a, input bit f);
        bus.adc0_in    = g_ramp ? W'(m_cyc) : W'(a0);
        bus.adc1_in    = g_ramp ? W'(-m_cyc) : W'($urandom);
        bus.arm        = a;
        bus.force_trig = f;
        step();
    endtask

    task automatic run_to_done(input int exp_n, input bit pulse_arm);
        int n = 0;
        while (!bus.done && n < 4 * N) begin
            cyc(int'($urandom_range(0, 400)) - 200, pulse_arm && (n % 3 == 1), 1'b0);
            n++;
        end
        bus.arm = 1'b0;
        chk("done_lat", n, exp_n);
    endtask

    task automatic readback(input bit ramp, input int b);
        logic [W-1:0] e;
        for (int k = 0; k < N; k++) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = AW'(k);
            cyc(0, 1'b0, 1'b0);
            if (ramp) begin
                e = W'(b + k);
                chk("ramp0", bus.rd_data0, e);
                e = W'(-(b + k));
                chk("ramp1", bus.rd_data1, e);
            end
        end
        bus.rd_en = 1'b0;
        cyc(0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.adc0_in    = '0;
        bus.adc1_in    = '0;
        bus.arm        = 1'b0;
        bus.force_trig = 1'b0;
        bus.trig_en    = 1'b0;
        bus.trig_level = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;

        rst = 1'b1;
        cyc(0, 1'b0, 1'b1);
        cyc(0, 1'b0, 1'b1);
        chk("rst_armed", bus.armed, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rv", bus.rd_valid, 0);
        chk("rst_d0", bus.rd_data0, 0);
        chk("rst_d1", bus.rd_data1, 0);
        rst = 1'b0;
        repeat (3) begin
            cyc(0, 1'b0, 1'b1);
            chk("idle_force", bus.busy, 0);
        end

        // forced trigger on a ramp; arm+force together only arms
        g_ramp = 1'b1;
        cyc(0, 1'b1, 1'b1);
        chk("armforce_armed", bus.armed, 1);
        chk("armforce_busy", bus.busy, 0);
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        base = m_cyc;
        cyc(0, 1'b0, 1'b1);
        chk("force_busy", bus.busy, 1);
        run_to_done(N - 1, 1'b0);
        g_ramp = 1'b0;
        readback(1'b1, base);

        // level trigger at 100
        bus.trig_level = W'(100);
        bus.trig_en    = 1'b1;
        cyc(-200, 1'b1, 1'b0);
        cyc(-50, 1'b0, 1'b0);
        cyc(99, 1'b0, 1'b0);
        chk("no_trig_99", bus.busy, 0);
        cyc(100, 1'b0, 1'b0);
        chk("trig_100", bus.busy, 1);
        run_to_done(N - 1, 1'b0);
        bus.rd_en   = 1'b1;
        bus.rd_addr = '0;
        cyc(0, 1'b0, 1'b0);
        chk("lvl_addr0", bus.rd_data0, 100);
        bus.rd_en = 1'b0;

        // already above threshold when armed
        cyc(500, 1'b1, 1'b0);
        repeat (40) cyc(500, 1'b0, 1'b0);
        chk("hold_armed", bus.armed, 1);
        chk("hold_busy", bus.busy, 0);

        // signed thresholds
        bus.trig_level = W'(-8192);
        repeat (3) cyc(-8192, 1'b0, 1'b0);
        repeat (3) cyc(-8191, 1'b0, 1'b0);
        chk("min_no_trig", bus.busy, 0);
        bus.trig_level = W'(-100);
        cyc(-101, 1'b0, 1'b0);
        cyc(-101, 1'b0, 1'b0);
        chk("neg_no_trig", bus.busy, 0);
        cyc(-100, 1'b0, 1'b0);
        chk("neg_trig", bus.busy, 1);
        run_to_done(N - 1, 1'b0);
        bus.trig_en = 1'b0;

        // arm ignored during capture, then re-arm from DONE
        cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b0, 1'b1);
        run_to_done(N - 1, 1'b1);
        cyc(0, 1'b1, 1'b0);
        chk("rearm", bus.armed, 1);
        cyc(0, 1'b0, 1'b1);
        run_to_done(N - 1, 1'b0);
        readback(1'b0, 0);

        // reset at T+5 abandons the capture
        cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b0, 1'b1);
        repeat (4) cyc(0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_armed", bus.armed, 0);
        chk("midrst_done", bus.done, 0);
        repeat (N) begin
            cyc(0, 1'b0, 1'b0);
            chk("midrst_no_done", bus.done, 0);
        end
        cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b0, 1'b1);
        run_to_done(N - 1, 1'b0);
        readback(1'b0, 0);

        // random traffic
        bus.trig_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 31) == 0)
                bus.trig_level = W'(int'($urandom_range(0, 400)) - 200);
            if ($urandom_range(0, 63) == 0)
                bus.trig_en = 1'($urandom);
            bus.rd_en   = 1'($urandom);
            bus.rd_addr = AW'($urandom);
            cyc(int'($urandom_range(0, 600)) - 300, $urandom_range(0, 15) == 0,
                $urandom_range(0, 19) == 0);
        end
        rst       = 1'b0;
        bus.rd_en = 1'b0;
        cyc(0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
